// File: rtl/wb_led_fader.sv
// Wishbone classic slave driving 8 LEDs with per-channel 8-bit PWM brightness.
// Each channel's brightness steps by one LSB per prescaler tick toward its software target.
module wb_led_fader #(
  parameter int div_w = 16
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic [7:0]  led
);

  typedef enum logic [1:0] {
    ADR_TGT_LO = 2'd0,
    ADR_TGT_HI = 2'd1,
    ADR_CTRL   = 2'd2,
    ADR_STATUS = 2'd3
  } adr_e;

  logic [7:0]       r_tgt [8];
  logic [7:0]       r_cur [8];
  logic [div_w-1:0] r_div;
  logic [div_w-1:0] r_presc;
  logic             r_en;
  logic [7:0]       r_pwm;
  logic [7:0]       r_led;
  logic             r_ack;
  logic [31:0]      r_dat;

  adr_e        w_adr;
  logic        w_req;
  logic        w_wr;
  logic        w_ctrl_wr;
  logic        w_tick;
  logic [7:0]  w_busy;
  logic [31:0] w_mask;
  logic [31:0] w_ctrl;
  logic [31:0] w_ctrl_new;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Burst-type hints are accepted but every access is treated as classic.
  assign w_unused   = ^{wb_cti_i, wb_bte_i};

  assign w_adr      = adr_e'(wb_adr_i);
  assign w_req      = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr       = w_req & wb_we_i;
  assign w_ctrl_wr  = w_wr & (w_adr == ADR_CTRL);
  assign w_tick     = (r_presc == r_div);
  assign w_mask     = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign w_ctrl     = {r_en, {(31-div_w){1'b0}}, r_div};
  assign w_ctrl_new = (w_ctrl & ~w_mask) | (wb_dat_i & w_mask);

  always_comb begin
    for (int i = 0; i < 8; i++) w_busy[i] = (r_cur[i] != r_tgt[i]);
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    w_rdata = '0;
    case (w_adr)
      ADR_TGT_LO: w_rdata = {r_tgt[3], r_tgt[2], r_tgt[1], r_tgt[0]};
      ADR_TGT_HI: w_rdata = {r_tgt[7], r_tgt[6], r_tgt[5], r_tgt[4]};
      ADR_CTRL:   w_rdata = w_ctrl;
      ADR_STATUS: w_rdata = {16'h0000, r_led, w_busy};
      default:    w_rdata = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      if (w_req && !wb_we_i) r_dat <= w_rdata;
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      // NOTE: the target/brightness arrays are plain flops, not RAM, so they take the reset.
      for (int i = 0; i < 8; i++) r_tgt[i] <= '0;
      r_div <= '0;
      r_en  <= 1'b0;
    end else if (w_wr) begin
      case (w_adr)
        ADR_TGT_LO, ADR_TGT_HI: begin
          for (int b = 0; b < 4; b++)
            if (wb_sel_i[b]) r_tgt[{wb_adr_i[0], 2'(b)}] <= wb_dat_i[8*b +: 8];
        end
        ADR_CTRL: begin
          r_div <= w_ctrl_new[div_w-1:0];
          r_en  <= w_ctrl_new[31];
        end
        default: ;
      endcase
    end
  end

  // A tick uses the targets as they stood before this edge.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_presc <= '0;
      for (int i = 0; i < 8; i++) r_cur[i] <= '0;
    end else begin
      if (w_ctrl_wr || w_tick) r_presc <= '0;
      else                     r_presc <= r_presc + div_w'(1);
      if (w_tick) begin
        for (int i = 0; i < 8; i++) begin
          if (r_cur[i] < r_tgt[i])      r_cur[i] <= r_cur[i] + 8'd1;
          else if (r_cur[i] > r_tgt[i]) r_cur[i] <= r_cur[i] - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_pwm <= '0;
      r_led <= '0;
    end else begin
      r_pwm <= r_en ? r_pwm + 8'd1 : 8'd0;
      for (int i = 0; i < 8; i++) r_led[i] <= r_en & (r_pwm < r_cur[i]);
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign led      = r_led;

endmodule

// File: tb/tb_wb_led_fader.sv
// Bench for wb_led_fader: directed scenarios plus random bus traffic, checked every
// cycle against a behavioural model of the register/fade/PWM rules.
module tb_wb_led_fader;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic [1:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [2:0]  wb_cti_i = '0;
  logic [1:0]  wb_bte_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  logic [7:0]  led;

  int n_tests = 0;
  int n_fail  = 0;

  wb_led_fader dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .led(led)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  // Reference model: integer brightness levels, tick counter and PWM phase.
  int          m_tgt [8];
  int          m_cur [8];
  int          m_div   = 0;
  int          m_presc = 0;
  int          m_pwm   = 0;
  bit          m_en    = 1'b0;
  bit          m_ack   = 1'b0;
  logic [31:0] m_dat   = '0;
  logic [7:0]  m_led   = '0;

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] r;
    r = '0;
    if (a < 2) begin
      for (int b = 0; b < 4; b++) r[8*b +: 8] = 8'(m_tgt[4*a + b]);
    end else if (a == 2) begin
      r = {m_en, 15'd0, 16'(m_div)};
    end else begin
      for (int i = 0; i < 8; i++) r[i] = (m_cur[i] != m_tgt[i]);
      r[15:8] = m_led;
    end
    return r;
  endfunction

  always @(posedge wb_clk or posedge wb_rst) begin : model
    bit          req;
    bit          tick;
    logic [31:0] w;
    if (wb_rst) begin
      for (int i = 0; i < 8; i++) begin m_tgt[i] = 0; m_cur[i] = 0; end
      m_div = 0; m_presc = 0; m_pwm = 0; m_en = 1'b0;
      m_ack = 1'b0; m_dat = '0; m_led = '0;
    end else begin
      req  = wb_cyc_i && wb_stb_i && !m_ack;
      tick = (m_presc == m_div);
      if (req && !wb_we_i) m_dat = model_read(int'(wb_adr_i));
      for (int i = 0; i < 8; i++) m_led[i] = m_en && (m_pwm < m_cur[i]);
      m_pwm = m_en ? (m_pwm + 1) % 256 : 0;
      if (tick)
        for (int i = 0; i < 8; i++)
          m_cur[i] = m_cur[i] + ((m_cur[i] < m_tgt[i]) ? 1 : (m_cur[i] > m_tgt[i]) ? -1 : 0);
      m_presc = tick ? 0 : m_presc + 1;
      if (req && wb_we_i) begin
        if (wb_adr_i < 2) begin
          for (int b = 0; b < 4; b++)
            if (wb_sel_i[b]) m_tgt[4*wb_adr_i + b] = int'(wb_dat_i[8*b +: 8]);
        end else if (wb_adr_i == 2) begin
          w = model_read(2);
          for (int b = 0; b < 4; b++)
            if (wb_sel_i[b]) w[8*b +: 8] = wb_dat_i[8*b +: 8];
          m_div   = int'(w[15:0]);
          m_en    = w[31];
          m_presc = 0;
        end
      end
      m_ack = req;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
    chk("ack", {31'd0, wb_ack_o}, {31'd0, m_ack});
    chk("led", {24'd0, led}, {24'd0, m_led});
    chk("err_rty", {30'd0, wb_err_o, wb_rty_o}, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
    wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    step();
    chk("wr_ack", {31'd0, wb_ack_o}, 32'd1);
    wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    wb_adr_i = a; wb_sel_i = 4'hF;
    wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    step();
    chk("rd_ack", {31'd0, wb_ack_o}, 32'd1);
    chk("rd_dat", wb_dat_o, m_dat);
    d = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();
  endtask

  initial begin : stim
    logic [31:0] d;
    int          cnt0;
    int          cnt1;
    int          acks;
    logic [5:0]  pat;

    // Reset and readback
    repeat (3) @(posedge wb_clk);
    #1 wb_rst = 1'b0;
    step();
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_led", {24'd0, led}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    for (int a = 0; a < 4; a++) begin
      wb_read(2'(a), d);
      chk("rst_readback", d, 32'd0);
    end

    // Byte selects
    wb_write(2'd0, 32'hAABBCCDD, 4'b0101);
    wb_read(2'd0, d);
    chk("sel_readback", d, 32'h00BB00DD);
    wb_read(2'd3, d);
    chk("sel_busy", {24'd0, d[7:0]}, 32'h05);

    // Fade timing with fade_div=3
    wb_write(2'd0, 32'h0, 4'hF);
    wb_write(2'd1, 32'h0, 4'hF);
    idle(260);
    wb_read(2'd3, d);
    chk("settled_status", d, 32'h0);
    wb_write(2'd2, 32'h80000003, 4'hF);
    wb_write(2'd0, 32'h00000004, 4'hF);
    idle(8);
    wb_read(2'd3, d);
    chk("fade_busy_mid", {31'd0, d[0]}, 32'd1);
    idle(6);
    wb_read(2'd3, d);
    chk("fade_busy_done", {24'd0, d[7:0]}, 32'd0);

    // Fade down then retarget upward mid-fade
    wb_write(2'd2, 32'h80000000, 4'hF);
    wb_write(2'd0, 32'h0000000A, 4'hF);
    idle(20);
    wb_write(2'd2, 32'h80000007, 4'hF);
    wb_write(2'd0, 32'h00000000, 4'b0001);
    idle(22);
    wb_write(2'd0, 32'h0000000C, 4'b0001);
    idle(120);
    cnt0 = 0;
    for (int k = 0; k < 256; k++) begin step(); cnt0 += int'(led[0]); end
    chk("retarget_duty", 32'(cnt0), 32'd12);

    // PWM duty and enable clear
    wb_write(2'd1, 32'h0, 4'hF);
    wb_write(2'd0, 32'h000040FF, 4'hF);
    wb_write(2'd2, 32'h80000000, 4'hF);
    idle(300);
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      cnt0 += int'(led[0]);
      cnt1 += int'(led[1]);
    end
    chk("duty_ch0", 32'(cnt0), 32'd255);
    chk("duty_ch1", 32'(cnt1), 32'd64);
    wb_write(2'd2, 32'h0, 4'hF);
    chk("enable_clear_led", {24'd0, led}, 32'd0);

    // Held strobe, STATUS write ignored
    wb_write(2'd0, 32'h0, 4'hF);
    idle(260);
    wb_adr_i = 2'd3; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    acks = 0; pat = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      acks += int'(wb_ack_o);
      pat[k] = wb_ack_o;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();
    chk("held_stb_acks", 32'(acks), 32'd3);
    chk("held_stb_pattern", {26'd0, pat}, 32'b010101);
    wb_write(2'd3, 32'hFFFFFFFF, 4'hF);
    wb_read(2'd3, d);
    chk("status_write_ignored", d, 32'h0);

    // Random traffic against the model
    for (int k = 0; k < 150; k++) begin
      logic [1:0]  a;
      logic [31:0] v;
      a = 2'($urandom_range(0, 3));
      v = $urandom;
      if (a == 2'd2) v = v & 32'hFFFF0007;
      if ($urandom_range(0, 1) == 1) wb_write(a, v, 4'($urandom_range(0, 15)));
      else                           wb_read(a, d);
      idle($urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of an acked read
    wb_write(2'd0, 32'h000000FF, 4'hF);
    wb_write(2'd2, 32'h80000000, 4'hF);
    idle(100);
    wb_adr_i = 2'd0; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge wb_clk);
    #2;
    chk("pre_rst_ack", {31'd0, wb_ack_o}, 32'd1);
    wb_rst = 1'b1;
    #1;
    chk("async_rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("async_rst_led", {24'd0, led}, 32'd0);
    chk("async_rst_dat", wb_dat_o, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge wb_clk);
    #1 wb_rst = 1'b0;
    step();
    for (int a = 0; a < 4; a++) begin
      wb_read(2'(a), d);
      chk("post_rst_readback", d, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
